prio_seg_scan: RTL
==================

PRIO_SEG_SCAN -- requirements
Module: prio_seg_scan

Interface
REQ-001 The block SHALL have parameter N_REQ, default 16, meaning the number of request lines (legal range 2..99).
REQ-002 The block SHALL have parameter SCAN_DIV, default 1000, meaning clocks per digit-scan slot (legal range >=2).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-004 Port list (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: async active-low reset.
- ei_n, in, 1: encoder enable, active low.
- req_n, in, N_REQ: request lines, active low; index N_REQ-1 has highest priority.
- lock_mode, in, 1: 1 = first-press lock mode; 0 = live tracking.
- clr, in, 1: single-cycle release of the lock.
- le, in, 1: display latch; 1 = hold the display register.
- lt_n, in, 1: lamp test, active low.
- seg, out, 7: segments a..g at bits 0..6, active high.
- dp, out, 1: decimal point, constant 0.
- dig_n, out, 2: digit enables, active low, one-hot; bit0 = ones, bit1 = tens.
- code, out, 7: encoded winning index (binary).
- valid, out, 1: code is meaningful.
- locked, out, 1: FSM is in LOCKED.

Function
REQ-005 Each of req_n, ei_n, lock_mode, clr, le and lt_n SHALL pass through a 2-flop synchronizer before use.
REQ-006 The encoder SHALL select the highest index i with synchronized req_n[i]=0. Its gs flag SHALL be 1 iff such an i exists and synchronized ei_n=0.
REQ-007 Latency from a req_n edge to a code/valid update SHALL be 3 clocks: 2 synchronizer stages plus 1 output register.
REQ-008 The FSM SHALL have two states, IDLE and LOCKED; locked=1 only in LOCKED.
REQ-009 In IDLE, code/valid SHALL load the encoder result every clock. If gs=0, valid=0 and code holds its previous value.
REQ-010 In IDLE with lock_mode=1 and gs=1, the FSM SHALL go to LOCKED and capture the winning code in that same update.
REQ-011 In LOCKED, code/valid SHALL be frozen regardless of req_n or ei_n. The only exit is clr=1, which returns the FSM to IDLE.
REQ-012 When clr and a new gs arrive in the same cycle, clr SHALL win: the FSM goes to IDLE, and it may lock on the next cycle.
REQ-013 If lock_mode falls while in LOCKED, the FSM SHALL stay LOCKED until clr. clr in IDLE SHALL have no effect.
REQ-014 The display register (tens, ones, dvalid) SHALL load the BCD of code and valid each clock while le=0, and SHALL hold while le=1. The FSM keeps running while le=1.
REQ-015 Binary-to-BCD conversion SHALL be exact for 0..98 (tens = code/10, ones = code%10).
REQ-016 A scan counter SHALL count 0..SCAN_DIV-1 and wrap. On wrap the active digit SHALL toggle, giving each digit a period of 2*SCAN_DIV clocks.
REQ-017 Segment priority SHALL be: lt_n=0 gives seg=7'h7F; else dvalid=0 gives seg=0; else the tens digit is blanked (seg=0) when tens=0; else seg is the 7-segment pattern of the active digit.
REQ-018 dig_n SHALL keep scanning even when blanked. seg and dig_n SHALL be registered and change in the same cycle.

Reset
REQ-019 While rst_n=0, all flops SHALL clear: FSM=IDLE, code=0, valid=0, locked=0, display register=0, scan counter=0, active digit=ones.
REQ-020 Reset outputs SHALL be seg=0, dig_n=2'b10, dp=0.
REQ-021 Reset asserted mid-lock SHALL abandon the lock immediately. Deassertion SHALL be internally synchronized.

Structure
REQ-022 Package prio_seg_pkg SHALL hold the FSM state enum, the 7-segment pattern constants for 0..9, and the CODE_W=7 constant.
REQ-023 Sub-module seg7_dec SHALL convert BCD to segments combinationally. Inputs 10..15 SHALL give seg=0.

Verification (N_REQ=16, SCAN_DIV=4)
REQ-024 Priority: req_n[3] and req_n[12] low, ei_n=0, lock_mode=0 -> code=12, valid=1 exactly 3 clocks later; tens digit shows 1, ones digit shows 2.
REQ-025 Lock and clear: lock_mode=1, press req_n[5], then press req_n[9] -> code stays 5 and locked=1. Pulse clr together with req_n[9] held -> IDLE for one cycle, then locks to 9.
REQ-026 Blanking: code=7 -> tens seg=0, ones seg is pattern 7. Release all requests with lock_mode=0 -> seg=0 on both digits while dig_n keeps alternating every 4 clocks.
REQ-027 Hold and lamp test: le=1, then change requests -> display unchanged while code updates. lt_n=0 -> seg=7'h7F on both digits.
REQ-028 Reset mid-lock: rst_n low while LOCKED on code 14 -> all outputs at reset values in the same cycle; after release, FSM=IDLE.
REQ-029 Enable: ei_n=1 with req_n[15] low -> valid=0 and no lock in either mode.

Source files
------------

// File: rtl/prio_seg_pkg.sv
// Shared types and constants for the priority encoder / 7-segment scanner.
package prio_seg_pkg;

  localparam int CODE_W = 7;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Segments a..g at bits 0..6, active high.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       dvalid;
  } disp_t;

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD to 7-segment decoder; non-decimal codes go dark.
module seg7_dec
  import prio_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = '0;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = '0;
    endcase
  end

endmodule

// File: rtl/prio_seg_scan.sv
// Synchronized priority encoder with optional first-press lock, driving a
// two-digit multiplexed 7-segment display.
module prio_seg_scan
  import prio_seg_pkg::*;
#(
  parameter int N_REQ    = 16,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ei_n,
  input  logic [N_REQ-1:0]  req_n,
  input  logic              lock_mode,
  input  logic              clr,
  input  logic              le,
  input  logic              lt_n,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [1:0]        dig_n,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              locked
);

  localparam int SW    = N_REQ + 5;
  localparam int CNT_W = $clog2(SCAN_DIV);
  // Synchronizers reset to the inactive level of each input.
  localparam logic [SW-1:0] SYNC_RST = {{N_REQ{1'b1}}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  // Reset asserts asynchronously, releases on the clock.
  logic [1:0] rst_pipe;
  logic       rst_s_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  assign rst_s_n = rst_pipe[1];

  logic [SW-1:0]    s1, s2;
  logic [N_REQ-1:0] req_s;
  logic             ei_s, lock_s, clr_s, le_s, lt_s;
  always_ff @(posedge clk or negedge rst_s_n)
    if (!rst_s_n) begin
      s1 <= SYNC_RST;
      s2 <= SYNC_RST;
    end else begin
      s1 <= {req_n, ei_n, lock_mode, clr, le, lt_n};
      s2 <= s1;
    end
  assign {req_s, ei_s, lock_s, clr_s, le_s, lt_s} = s2;

  // Ascending scan: the last hit, i.e. the highest index, wins.
  logic              enc_hit, gs;
  logic [CODE_W-1:0] enc_idx;
  always_comb begin
    enc_hit = 1'b0;
    enc_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (!req_s[i]) begin
        enc_hit = 1'b1;
        enc_idx = CODE_W'(i);
      end
  end
  assign gs = enc_hit & ~ei_s;

  state_e state_q, state_nxt;
  always_ff @(posedge clk or negedge rst_s_n)
    if (!rst_s_n) state_q <= IDLE;
    else          state_q <= state_nxt;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (gs && lock_s) state_nxt = LOCKED;
      LOCKED:  if (clr_s)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  always_ff @(posedge clk or negedge rst_s_n)
    if (!rst_s_n) begin
      code_q  <= '0;
      valid_q <= 1'b0;
    end else if (state_q == IDLE) begin
      valid_q <= gs;
      if (gs) code_q <= enc_idx;
    end

  disp_t disp_q;
  always_ff @(posedge clk or negedge rst_s_n)
    if (!rst_s_n) disp_q <= '0;
    else if (!le_s) begin
      disp_q.tens   <= 4'(code_q / CODE_W'(10));
      disp_q.ones   <= 4'(code_q % CODE_W'(10));
      disp_q.dvalid <= valid_q;
    end

  logic [1:0][3:0] disp_bcd;
  logic [1:0][6:0] dig_seg;
  assign disp_bcd = {disp_q.tens, disp_q.ones};
  for (genvar g = 0; g < 2; g++) begin : g_dig
    seg7_dec u_dec (.bcd(disp_bcd[g]), .seg(dig_seg[g]));
  end

  logic [CNT_W-1:0] cnt_q;
  logic             dsel_q;  // 0 = ones, 1 = tens
  always_ff @(posedge clk or negedge rst_s_n)
    if (!rst_s_n) begin
      cnt_q  <= '0;
      dsel_q <= 1'b0;
    end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_q  <= '0;
      dsel_q <= ~dsel_q;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end

  logic [6:0] seg_nxt;
  always_comb begin
    seg_nxt = dig_seg[dsel_q];
    if (!lt_s)                              seg_nxt = 7'h7F;
    else if (!disp_q.dvalid)                seg_nxt = '0;
    else if (dsel_q && disp_q.tens == 4'd0) seg_nxt = '0;
  end

  // Both registered from the same digit select so they switch together.
  logic [6:0] seg_q;
  logic [1:0] dig_n_q;
  always_ff @(posedge clk or negedge rst_s_n)
    if (!rst_s_n) begin
      seg_q   <= '0;
      dig_n_q <= 2'b10;
    end else begin
      seg_q   <= seg_nxt;
      dig_n_q <= dsel_q ? 2'b01 : 2'b10;
    end

  assign seg    = seg_q;
  assign dig_n  = dig_n_q;
  assign dp     = 1'b0;
  assign code   = code_q;
  assign valid  = valid_q;
  assign locked = (state_q == LOCKED);

endmodule
